// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug probe capture block.
package dbg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        CAPTURE = 2'b10,
        DONE    = 2'b11
    } state_t;

    localparam logic [1:0] MODE_ALL = 2'b00;
    localparam logic [1:0] MODE_ANY = 2'b01;
    localparam logic [1:0] MODE_PAR = 2'b10;
    localparam logic [1:0] MODE_CHG = 2'b11;

    // count must represent 0..DEPTH inclusive
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dbg_probe_capture_if.sv
// Probe, control and readout bundle between the probed datapath and the capture block.
interface dbg_probe_capture_if
    import dbg_pkg::*;
#(
    parameter int unsigned CH    = 16,
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned SEL_W = $clog2(CH);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    // keep attributes stop synthesis from pruning the observed nets
    (* keep = "true", dont_touch = "true" *) logic [CH*W-1:0] probe_in;
    (* keep = "true", dont_touch = "true" *) logic [1:0]      mode;
    (* keep = "true", dont_touch = "true" *) logic            arm;
    (* keep = "true", dont_touch = "true" *) logic            trig;
    (* keep = "true", dont_touch = "true" *) logic [SEL_W-1:0] rd_sel;
    (* keep = "true", dont_touch = "true" *) logic [IDX_W-1:0] rd_idx;
    logic [W-1:0]     rd_data;
    logic [CNT_W-1:0] count;
    logic             armed;
    logic             done;
    logic             led;

    modport master (
        output probe_in, mode, arm, trig, rd_sel, rd_idx,
        input  rd_data, count, armed, done, led
    );

    modport slave (
        input  probe_in, mode, arm, trig, rd_sel, rd_idx,
        output rd_data, count, armed, done, led
    );

endinterface

// File: rtl/dbg_reduce.sv
// Next-value logic for the status LED: per-mode reduction across all probed channels.
module dbg_reduce
    import dbg_pkg::*;
#(
    parameter int unsigned CH = 16,
    parameter int unsigned W  = 16
) (
    input  logic [CH*W-1:0] probe_in,
    input  logic [CH*W-1:0] prev,
    input  logic [1:0]      mode,
    output logic            led_nxt_c
);

    logic all_nz;
    logic any_nz;
    logic nz;

    always_comb begin
        all_nz = 1'b1;
        any_nz = 1'b0;
        nz     = 1'b0;
        for (int c = 0; c < int'(CH); c++) begin
            nz     = |probe_in[c*W +: W];
            all_nz = all_nz & nz;
            any_nz = any_nz | nz;
        end
    end

    always_comb begin
        led_nxt_c = 1'b0;
        case (mode)
            MODE_ALL: led_nxt_c = all_nz;
            MODE_ANY: led_nxt_c = any_nz;
            MODE_PAR: led_nxt_c = ^probe_in;
            MODE_CHG: led_nxt_c = (probe_in != prev);
            default:  led_nxt_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/dbg_probe_capture.sv
// Debug probe: triggered multi-channel snapshot buffer with registered readout and status LED.
module dbg_probe_capture
    import dbg_pkg::*;
#(
    parameter int unsigned CH    = 16,
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 8
) (
    (* keep = "true", dont_touch = "true" *) input logic clk,
    (* keep = "true", dont_touch = "true" *) input logic rst,
    dbg_probe_capture_if.slave bus
);

    localparam int unsigned SEL_W    = $clog2(CH);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = cnt_width(DEPTH);
    localparam int unsigned PAD_BITS = (1 << SEL_W) * W;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              armed;
    logic              done;
    logic              led;
    logic [W-1:0]      rd_data;
    logic [CH*W-1:0]   prev;
    logic [CH*W-1:0]   mem [DEPTH];

    logic              led_nxt_c;
    logic [PAD_BITS-1:0] row_pad_c;
    logic [W-1:0]      rd_word_c;

    dbg_reduce #(.CH(CH), .W(W)) u_reduce (
        .probe_in  (bus.probe_in),
        .prev      (prev),
        .mode      (bus.mode),
        .led_nxt_c (led_nxt_c)
    );

    // Row is zero-padded to a power-of-two channel count so out-of-range rd_sel reads 0
    always_comb begin
        row_pad_c = PAD_BITS'(mem[bus.rd_idx]);
        rd_word_c = '0;
        if ({1'b0, bus.rd_idx} < count) begin
            rd_word_c = row_pad_c[32'(bus.rd_sel)*W +: W];
        end
    end

    // Write pointer is count itself; it is 0 whenever ARMED is entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            armed   <= 1'b0;
            done    <= 1'b0;
            led     <= 1'b0;
            rd_data <= '0;
            prev    <= '0;
            for (int d = 0; d < int'(DEPTH); d++) begin
                mem[d] <= '0;
            end
        end else begin
            prev    <= bus.probe_in;
            led     <= led_nxt_c;
            rd_data <= rd_word_c;
            case (state)
                IDLE: begin
                    if (bus.arm) begin
                        state <= ARMED;
                        armed <= 1'b1;
                    end
                end
                ARMED: begin
                    if (bus.trig) begin
                        mem[count[IDX_W-1:0]] <= bus.probe_in;
                        count <= count + CNT_W'(1);
                        state <= CAPTURE;
                        armed <= 1'b0;
                    end
                end
                CAPTURE: begin
                    mem[count[IDX_W-1:0]] <= bus.probe_in;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(DEPTH - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.arm) begin
                        state <= ARMED;
                        armed <= 1'b1;
                        done  <= 1'b0;
                        count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.count   = count;
    assign bus.armed   = armed;
    assign bus.done    = done;
    assign bus.led     = led;
    assign bus.rd_data = rd_data;

endmodule

// File: doc/dbg_probe_capture.md
# dbg_probe_capture

Parametrised debug probe for the CPU datapath. It keeps CH internal channels of W bits each observable after synthesis and drives a mode-selectable registered status LED. It also records DEPTH consecutive snapshots of all channels after an armed trigger and returns any captured word through a registered read port. It sits beside the CPU core on the FPGA top level, fed by the same internal buses: µ-address, opcode, cycle counter, ACC, ALU, PC, MAR, memory data and MR.

## Interface
Parameters:
- CH, 16: number of probed channels (≥2)
- W, 16: bits per channel (≥1)
- DEPTH, 8: capture snapshots (power of two, ≥2)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- probe_in  in  CH*W  channel c occupies bits [c*W +: W]
- mode  in  2  LED function: 00 all-nonzero, 01 any-nonzero, 10 parity, 11 change
- arm  in  1  level; arms capture
- trig  in  1  level; starts capture when armed
- rd_sel  in  clog2(CH)  channel to read
- rd_idx  in  clog2(DEPTH)  snapshot to read
- rd_data  out  W  captured word; reset 0
- count  out  clog2(DEPTH)+1  snapshots stored; reset 0
- armed  out  1  high in ARMED; reset 0
- done  out  1  high in DONE; reset 0
- led  out  1  registered status; reset 0

Every input port carries a keep/DONT_TOUCH attribute so probed nets survive optimisation.

## Operation
- State machine: IDLE → ARMED on arm. ARMED → CAPTURE on trig. CAPTURE → DONE after DEPTH samples. DONE → ARMED on arm, which clears count to 0. All other inputs are ignored in each state.
- In IDLE, arm and trig high in the same cycle give ARMED only. The trigger is not taken.
- The trigger cycle writes probe_in to snapshot 0 and sets count to 1. Each following CAPTURE cycle writes the next index and increments count. The write at index DEPTH-1 makes count = DEPTH and the next state DONE.
- arm during CAPTURE is ignored. trig in IDLE or DONE is ignored.
- Buffer contents are held in IDLE and DONE. They are cleared only by rst.
- Readout: rd_data ← buffer[rd_idx][rd_sel] if rd_idx < count and rd_sel < CH, otherwise 0.
- LED modes:
  - 00: a channel counts as true if any of its bits is 1. LED = AND over all CH channels.
  - 01: LED = OR over all CH channels.
  - 10: LED = XOR of all CH*W bits.
  - 11: LED = 1 if probe_in differs from its value one cycle earlier. The previous-sample register resets to 0.
- A mode change takes effect on the next edge. There is no hold-over from the old mode.

## Timing
- led lags probe_in and mode by one cycle.
- rd_data lags rd_sel and rd_idx by one cycle. A read in the same cycle as a write to the addressed slot returns the old contents.
- armed and done are registered state decodes. Both are valid one cycle after the causing input.
- Trigger to done = DEPTH cycles. Trigger to the first readable sample = 1 cycle.
- rst at any point, including mid-capture, has the following effect within the same cycle:
  - state goes to IDLE
  - count, rd_data and led go to 0
  - all buffer entries and the previous-sample register go to 0
- Normal operation resumes on the first edge after rst falls.

## Structure
- Package dbg_pkg holds:
  - state enum: IDLE, ARMED, CAPTURE, DONE
  - mode constants: MODE_ALL, MODE_ANY, MODE_PAR, MODE_CHG
  - helper width function for count
- Sub-module dbg_reduce: purely combinational, parameterised by CH and W. Inputs are probe_in, the previous sample and mode. Output is the next LED value. The top level registers it.
- The top level owns the FSM, write pointer (equal to count), buffer array and read register.

## Test plan
- Reset behaviour: assert rst mid-capture at count = 3 → next cycle state = IDLE, count = 0, led = 0. After release, reading idx 0 returns 0.
- Basic capture (CH = 16, W = 16, DEPTH = 8):
  - Stimulus: arm, then trig with channel 5 driven to 0x00A0+k on cycle k.
  - Response: done rises 8 cycles after trig, count = 8, rd_sel = 5, rd_idx = 3 gives 0x00A3 one cycle later.
- Boundary and read rules:
  - trig in IDLE → no state change.
  - arm and trig together in IDLE → armed = 1, count = 0.
  - rd_idx = 6 with count = 4 → rd_data = 0.
- LED modes:
  - mode 00, all channels 0x0001 except one at 0 → led 0; make that channel 0x8000 → led 1 next cycle.
  - mode 01, all channels 0 → led 0.
  - mode 10, a single bit set → led 1.
- Change detect (mode 11): hold probe_in constant → led 0. Flip one bit for one cycle → led 1 for exactly that cycle plus the return cycle, delayed by 1.
- Re-arm from DONE: assert arm → count = 0, armed = 1, old data reads 0. The next trig recaptures from index 0.
